// File: rtl/execute_stage_mdu_pkg.sv
// Shared types and encodings for the execute stage and its iterative multiply/divide unit.
package execute_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_MUL,
      MDU_DIV,
      MDU_DONE
   } mdu_state_t;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_RESULT  = 2'd1;
   localparam logic [1:0] FWD_MEM     = 2'd2;

   localparam logic [2:0] BR_BEQ  = 3'd0;
   localparam logic [2:0] BR_BNE  = 3'd1;
   localparam logic [2:0] BR_BLT  = 3'd4;
   localparam logic [2:0] BR_BGE  = 3'd5;
   localparam logic [2:0] BR_BLTU = 3'd6;
   localparam logic [2:0] BR_BGEU = 3'd7;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_AND   = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd3;
   localparam logic [4:0] ALU_XOR   = 5'd4;
   localparam logic [4:0] ALU_SLT   = 5'd5;
   localparam logic [4:0] ALU_SLTU  = 5'd6;
   localparam logic [4:0] ALU_SLL   = 5'd7;
   localparam logic [4:0] ALU_SRL   = 5'd8;
   localparam logic [4:0] ALU_SRA   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;

endpackage

// File: rtl/execute_stage_mdu_if.sv
// Execute-stage bus: decode-side inputs, redirect/stall feedback and E->M register outputs.
interface execute_stage_mdu_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5
);
   logic                  i_valid, i_flush, i_stall_mem;
   logic [ADDR_WIDTH-1:0] i_pc, i_pc_plus4;
   logic [DATA_WIDTH-1:0] i_rs1_data, i_rs2_data, i_result, i_forward_value, i_imm_ext;
   logic [1:0]            i_forward_rs1_exec, i_forward_rs2_exec;
   logic [4:0]            i_alu_control;
   logic                  i_alu_src, i_branch, i_jump, i_pc_target_src, i_md_en;
   logic [2:0]            i_func3, i_result_src;
   logic [REG_ADDR_W-1:0] i_rd_addr;
   logic                  i_reg_we, i_mem_we;

   logic                  o_pc_src, o_stall;
   logic [ADDR_WIDTH-1:0] o_pc_target, o_pc_plus4;
   logic                  o_valid, o_reg_we, o_mem_we;
   logic [DATA_WIDTH-1:0] o_alu_result, o_write_data;
   logic [REG_ADDR_W-1:0] o_rd_addr;
   logic [2:0]            o_result_src, o_func3;

   modport master (
      output i_valid, i_flush, i_stall_mem, i_pc, i_pc_plus4, i_rs1_data, i_rs2_data,
             i_result, i_forward_value, i_imm_ext, i_forward_rs1_exec, i_forward_rs2_exec,
             i_alu_control, i_alu_src, i_branch, i_jump, i_pc_target_src, i_md_en,
             i_func3, i_result_src, i_rd_addr, i_reg_we, i_mem_we,
      input  o_pc_src, o_stall, o_pc_target, o_pc_plus4, o_valid, o_reg_we, o_mem_we,
             o_alu_result, o_write_data, o_rd_addr, o_result_src, o_func3
   );

   modport slave (
      input  i_valid, i_flush, i_stall_mem, i_pc, i_pc_plus4, i_rs1_data, i_rs2_data,
             i_result, i_forward_value, i_imm_ext, i_forward_rs1_exec, i_forward_rs2_exec,
             i_alu_control, i_alu_src, i_branch, i_jump, i_pc_target_src, i_md_en,
             i_func3, i_result_src, i_rd_addr, i_reg_we, i_mem_we,
      output o_pc_src, o_stall, o_pc_target, o_pc_plus4, o_valid, o_reg_we, o_mem_we,
             o_alu_result, o_write_data, o_rd_addr, o_result_src, o_func3
   );
endinterface

// File: rtl/execute_stage_mdu_alu.sv
// Datapath building blocks shared by the pipeline: ALU with compare flags, adder and muxes.
module alu import execute_pkg::*; #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [4:0]   ctrl,
   output logic [W-1:0] y,
   output logic         eq,
   output logic         lt,
   output logic         ltu
);
   localparam int SW = $clog2(W);
   logic [SW-1:0] shamt;

   assign shamt = b[SW-1:0];
   assign eq    = (a == b);
   assign lt    = ($signed(a) < $signed(b));
   assign ltu   = (a < b);

   always_comb begin
      y = '0;
      case (ctrl)
         ALU_ADD:   y = a + b;
         ALU_SUB:   y = a - b;
         ALU_AND:   y = a & b;
         ALU_OR:    y = a | b;
         ALU_XOR:   y = a ^ b;
         ALU_SLT:   y[0] = lt;
         ALU_SLTU:  y[0] = ltu;
         ALU_SLL:   y = a << shamt;
         ALU_SRL:   y = a >> shamt;
         ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
         ALU_PASSB: y = b;
         default:   y = '0;
      endcase
   end
endmodule

module adder #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = a + b;
endmodule

module mux2to1 #(
   parameter int W = 64
) (
   input  logic         sel,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   output logic [W-1:0] y
);
   assign y = sel ? d1 : d0;
endmodule

module mux3to1 #(
   parameter int W = 64
) (
   input  logic [1:0]   sel,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   output logic [W-1:0] y
);
   assign y = (sel == 2'd0) ? d0 : (sel == 2'd1) ? d1 : d2;
endmodule

// File: rtl/execute_stage_mdu_mdu_iterative.sv
// One-bit-per-cycle multiply/divide: shift-add multiply, restoring divide on magnitudes,
// sign fix-up applied to the held result, divide-by-zero and MIN/-1 resolved at issue.
module mdu_iterative import execute_pkg::*; #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         flush,
   input  logic         hold,
   input  logic [2:0]   func3,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result
);
   localparam int CW = $clog2(W + 1);
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

   mdu_state_t      state;
   md_op_t          op;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    hi, lo, opnd;
   logic            neg;

   logic            is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic [W-1:0]    mag_a, mag_b;
   logic [W:0]      mul_sum, div_shift, div_diff;
   logic [2*W-1:0]  prod, prod_fix;

   assign is_div   = func3[2];
   assign sgn_a    = is_div ? ~func3[0] : (func3 != MD_MULHU);
   assign sgn_b    = is_div ? ~func3[0] : (func3 == MD_MUL || func3 == MD_MULH);
   assign neg_a    = sgn_a & a[W-1];
   assign neg_b    = sgn_b & b[W-1];
   assign mag_a    = neg_a ? ('0 - a) : a;
   assign mag_b    = neg_b ? ('0 - b) : b;
   assign div_zero = is_div & (b == '0);
   assign div_ovf  = is_div & ~func3[0] & (a == MIN) & (b == '1);

   // hi:lo is the product accumulator when multiplying, remainder:quotient when dividing
   assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
   assign div_shift = {hi, lo[W-1]};
   assign div_diff  = div_shift - {1'b0, opnd};

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state <= MDU_IDLE;
         cnt   <= '0;
         op    <= MD_MUL;
         hi    <= '0;
         lo    <= '0;
         opnd  <= '0;
         neg   <= 1'b0;
      end else begin
         case (state)
            MDU_IDLE: if (start) begin
               op <= md_op_t'(func3);
               if (div_zero) begin
                  hi    <= a;
                  lo    <= '1;
                  neg   <= 1'b0;
                  cnt   <= '0;
                  state <= MDU_DONE;
               end else if (div_ovf) begin
                  hi    <= '0;
                  lo    <= MIN;
                  neg   <= 1'b0;
                  cnt   <= '0;
                  state <= MDU_DONE;
               end else if (is_div) begin
                  hi    <= '0;
                  lo    <= mag_a;
                  opnd  <= mag_b;
                  neg   <= func3[1] ? neg_a : (neg_a ^ neg_b);
                  cnt   <= CW'(W);
                  state <= MDU_DIV;
               end else begin
                  hi    <= '0;
                  lo    <= mag_b;
                  opnd  <= mag_a;
                  neg   <= neg_a ^ neg_b;
                  cnt   <= CW'(W);
                  state <= MDU_MUL;
               end
            end
            MDU_MUL: begin
               hi  <= mul_sum[W:1];
               lo  <= {mul_sum[0], lo[W-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= MDU_DONE;
            end
            MDU_DIV: begin
               hi  <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
               lo  <= {lo[W-2:0], ~div_diff[W]};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= MDU_DONE;
            end
            MDU_DONE: if (!hold) state <= MDU_IDLE;
            default:  state <= MDU_IDLE;
         endcase
      end
   end

   assign busy     = (state == MDU_MUL) || (state == MDU_DIV);
   assign done     = (state == MDU_DONE);
   assign prod     = {hi, lo};
   assign prod_fix = neg ? ('0 - prod) : prod;

   always_comb begin
      result = '0;
      case (op)
         MD_MUL:                       result = prod_fix[W-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*W-1:W];
         MD_DIV, MD_DIVU:              result = neg ? ('0 - lo) : lo;
         default:                      result = neg ? ('0 - hi) : hi;
      endcase
   end
endmodule

// File: rtl/execute_stage_mdu.sv
// Execute stage: forwarding, ALU, branch/jump resolution, iterative MDU and the E->M register.
module execute_stage_mdu import execute_pkg::*; #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5
) (
   input logic                i_clk,
   input logic                i_arst,
   execute_stage_mdu_if.slave bus
);
   logic [DATA_WIDTH-1:0] src_a, store_data, src_b, alu_y, mdu_result;
   logic [ADDR_WIDTH-1:0] pc_imm, alu_addr, imm_addr;
   logic                  eq, lt, ltu, br_cond, md_issue, stall, mdu_busy, mdu_done;

   mux3to1 #(.W(DATA_WIDTH)) u_fwd_a (.sel(bus.i_forward_rs1_exec), .d0(bus.i_rs1_data),
      .d1(bus.i_result), .d2(bus.i_forward_value), .y(src_a));
   mux3to1 #(.W(DATA_WIDTH)) u_fwd_b (.sel(bus.i_forward_rs2_exec), .d0(bus.i_rs2_data),
      .d1(bus.i_result), .d2(bus.i_forward_value), .y(store_data));
   mux2to1 #(.W(DATA_WIDTH)) u_src_b (.sel(bus.i_alu_src), .d0(store_data),
      .d1(bus.i_imm_ext), .y(src_b));

   alu #(.W(DATA_WIDTH)) u_alu (.a(src_a), .b(src_b), .ctrl(bus.i_alu_control),
      .y(alu_y), .eq(eq), .lt(lt), .ltu(ltu));

   assign imm_addr = ADDR_WIDTH'(bus.i_imm_ext);
   assign alu_addr = ADDR_WIDTH'(alu_y);
   adder #(.W(ADDR_WIDTH)) u_pc_add (.a(bus.i_pc), .b(imm_addr), .y(pc_imm));
   mux2to1 #(.W(ADDR_WIDTH)) u_tgt (.sel(bus.i_pc_target_src), .d0(pc_imm),
      .d1(alu_addr), .y(bus.o_pc_target));

   always_comb begin
      br_cond = 1'b0;
      case (bus.i_func3)
         BR_BEQ:  br_cond = eq;
         BR_BNE:  br_cond = ~eq;
         BR_BLT:  br_cond = lt;
         BR_BGE:  br_cond = ~lt;
         BR_BLTU: br_cond = ltu;
         BR_BGEU: br_cond = ~ltu;
         default: br_cond = 1'b0;
      endcase
   end

   assign bus.o_pc_src = bus.i_valid & ~bus.i_flush & ~bus.i_md_en &
                         (bus.i_jump | (bus.i_branch & br_cond));

   assign md_issue = bus.i_valid & bus.i_md_en & ~bus.i_flush;

   mdu_iterative #(.W(DATA_WIDTH)) u_mdu (.clk(i_clk), .rst(i_arst), .start(md_issue),
      .flush(bus.i_flush), .hold(bus.i_stall_mem), .func3(bus.i_func3), .a(src_a),
      .b(store_data), .busy(mdu_busy), .done(mdu_done), .result(mdu_result));

   // busy covers the iterate states, ~done covers the issue cycle in IDLE
   assign stall       = md_issue & (mdu_busy | ~mdu_done);
   assign bus.o_stall = stall;

   always_ff @(posedge i_clk) begin
      if (i_arst || (!bus.i_stall_mem && (bus.i_flush || stall))) begin
         bus.o_valid      <= 1'b0;
         bus.o_reg_we     <= 1'b0;
         bus.o_mem_we     <= 1'b0;
         bus.o_alu_result <= '0;
         bus.o_write_data <= '0;
         bus.o_pc_plus4   <= '0;
         bus.o_rd_addr    <= '0;
         bus.o_result_src <= '0;
         bus.o_func3      <= '0;
      end else if (!bus.i_stall_mem) begin
         bus.o_valid      <= bus.i_valid;
         bus.o_reg_we     <= bus.i_reg_we;
         bus.o_mem_we     <= bus.i_mem_we;
         bus.o_alu_result <= mdu_done ? mdu_result : alu_y;
         bus.o_write_data <= store_data;
         bus.o_pc_plus4   <= bus.i_pc_plus4;
         bus.o_rd_addr    <= bus.i_rd_addr;
         bus.o_result_src <= bus.i_result_src;
         bus.o_func3      <= bus.i_func3;
      end
   end
endmodule

// File: doc/execute_stage_mdu.md
# execute_stage_mdu

Parametrised execute stage with an integrated iterative multiply/divide unit (RV M-extension) for the 5-stage pipeline. It resolves operand forwarding, ALU ops, branches and jump targets in one cycle. It runs MUL/DIV/REM through a one-bit-per-cycle FSM, stalling upstream stages while busy. It also owns the E→M pipeline register with hold, flush and bubble control.

## Interface
- ADDR_WIDTH, 64, PC/address width
- DATA_WIDTH, 64, operand width; even, ≥8
- REG_ADDR_W, 5, register index width
- i_clk  in  1  clock, rising edge
- i_arst  in  1  reset; synchronous, active-high
- i_valid  in  1  E-stage instruction valid
- i_flush  in  1  squash E-stage instruction (abort MDU)
- i_stall_mem  in  1  downstream stall; E→M register holds
- i_pc, i_pc_plus4  in  ADDR_WIDTH  instruction PC, PC+4
- i_rs1_data, i_rs2_data  in  DATA_WIDTH  register file operands
- i_result, i_forward_value  in  DATA_WIDTH  WB / MEM forwarding sources
- i_forward_rs1_exec, i_forward_rs2_exec  in  2  0=regfile, 1=i_result, 2=i_forward_value
- i_imm_ext  in  DATA_WIDTH  extended immediate
- i_alu_control  in  5  ALU op; i_alu_src  in  1  srcB: 0=rs2, 1=imm
- i_func3  in  3  branch condition / M-op select
- i_branch, i_jump, i_pc_target_src  in  1  branch, jump, target: 0=PC+imm, 1=ALU
- i_md_en  in  1  instruction is M-extension
- i_rd_addr  in  REG_ADDR_W; i_reg_we, i_mem_we  in  1; i_result_src  in  3
- o_pc_src  out  1  redirect taken
- o_pc_target  out  ADDR_WIDTH  redirect target (combinational)
- o_stall  out  1  hold F/D/E stages
- o_valid, o_reg_we, o_mem_we  out  1  registered
- o_alu_result, o_write_data  out  DATA_WIDTH  registered result / store data
- o_pc_plus4  out  ADDR_WIDTH; o_rd_addr  out  REG_ADDR_W; o_result_src  out  3; o_func3  out  3; all registered

## Operation
- Forwarding muxes select srcA and store data. srcB is store data or the immediate. The existing ALU computes the result and flags.
- Branch: beq/bne/blt/bge/bltu/bgeu on func3 0,1,4,5,6,7; other func3 not taken.
- o_pc_src = i_valid & ~i_flush & (i_jump | branch_taken).
- M ops by func3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU. Signed operands are converted to magnitudes at issue, and the result sign is corrected in DONE.
- MDU FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL/DIV when i_valid & i_md_en & ~i_flush. Operands latch and the counter loads DATA_WIDTH.
  - MUL/DIV perform one shift-add or restoring-subtract step per cycle and decrement the counter. At counter=1, go to DONE.
  - DONE→IDLE when ~i_stall_mem; otherwise stay in DONE, holding the result.
- Divide by zero: IDLE→DONE directly. Quotient = all ones; remainder = dividend.
- Signed overflow (MIN / −1): IDLE→DONE directly. Quotient = MIN; remainder = 0.
- MULH* return the upper DATA_WIDTH bits of the 2·DATA_WIDTH product; MUL returns the lower bits.
- o_stall = i_valid & i_md_en & ~i_flush & (state≠DONE).
- E→M register priority:
  1. reset clears all outputs.
  2. i_stall_mem holds.
  3. i_flush or o_stall loads a bubble (valid/reg_we/mem_we = 0, data 0).
  4. Otherwise the register loads. In DONE, o_alu_result comes from the MDU result.
- i_flush in any state forces IDLE next cycle and clears the counter. No result is written.

## Timing
- Non-M instructions: 1 cycle, E→M register loads at the next edge.
- M op, normal: issue cycle plus DATA_WIDTH iterate cycles, then DONE. o_stall is high for DATA_WIDTH+1 cycles, and the result is registered at the end of DONE.
- Divide by zero and overflow: o_stall high for 1 cycle; the register loads at the end of the following cycle.
- Reset: state IDLE, counter 0, every registered output 0, o_stall 0.
- o_pc_src and o_pc_target are combinational from E inputs. For an M op, o_pc_src is 0.
- Reset asserted during an MDU op: abort; IDLE next cycle.
- Simultaneous i_stall_mem and DONE: DONE persists and o_stall stays 0. The upstream stage must not advance, because i_stall_mem stalls it globally.

## Structure
- Package execute_pkg holds: the md_op_t enum (func3 encodings), the mdu_state_t enum, the forward-select constants, and the branch func3 constants.
- Sub-module mdu_iterative contains the FSM, counter, operand/remainder registers, sign fix-up and special cases. Its handshake is start/flush/hold → busy/done/result.
- Reuses the existing alu, adder, mux2to1 and mux3to1. The E→M register is inline.

## Test plan
- MUL −3·7 (DATA_WIDTH=64) → o_alu_result 0xFFFF_FFFF_FFFF_FFEB after exactly 65 stall cycles; o_reg_we=1.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM → 0xFFFF_FFFF_FFFF_FFFF; MULHU 0xFFFF…FFFF² → 0xFFFF…FFFE.
- DIVU 5/0 → all ones; REM 5/0 → 5; DIV 0x8000…0000/−1 → 0x8000…0000. o_stall is high for exactly 1 cycle in each case.
- Flush at iteration 10 of a DIV → IDLE next cycle, o_stall 0, bubble in E→M (o_reg_we=0). A following ADD 1+2 → 3 the next cycle.
- BNE rs1=4, rs2 forwarded via sel 2 = 4 → o_pc_src 0. With the forwarded value 5 → o_pc_src 1 and o_pc_target = PC+imm.
- i_stall_mem held for 3 cycles in DONE → outputs frozen, FSM stays DONE. Release → result loads once, FSM returns to IDLE.
